// File: rtl/pixel_stream_tx_pkg.sv
// rtl/pixel_stream_tx_pkg.sv - shared constants and FSM encoding for the pixel stream transmitter
//
// Contents:
//   PIX_W   - pixel width in bits
//   state_t - transmitter FSM state encoding
package pixel_stream_tx_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - two-entry valid/ready buffer (output register plus skid register)
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid, in_data   - write side; the producer never writes while full unless popping
//   out_valid, out_data - head entry, held stable until popped
//   out_ready           - consumer accepts the head entry this cycle
//   level               - number of occupied entries (0..2)
module skid_buf2 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   level
);

    logic [W-1:0] out_reg;
    logic [W-1:0] skid_reg;
    logic [1:0]   cnt;
    logic         pop;

    assign pop       = (cnt != 2'd0) && out_ready;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = out_reg;
    assign level     = cnt;

    // The head always lives in out_reg so the consumer sees a registered value;
    // skid_reg only holds the second entry while the head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 2'd0;
            out_reg  <= '0;
            skid_reg <= '0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (in_valid) begin
                        out_reg <= in_data;
                        cnt     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (in_valid && pop) begin
                        out_reg <= in_data;
                    end else if (in_valid) begin
                        skid_reg <= in_data;
                        cnt      <= 2'd2;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        out_reg <= skid_reg;
                        if (in_valid) begin
                            skid_reg <= in_data;
                        end else begin
                            cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - streams one frame from frame memory to a valid/ready pixel sink
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   start              - pulse that begins a frame (ignored unless idle)
//   busy               - frame in progress
//   frame_done         - one-cycle pulse after the eof pixel is accepted
//   mem_rd_en/mem_addr - frame-memory read strobe and raster address
//   mem_data           - read data, one cycle after mem_rd_en
//   data_valid/data_o  - pixel output, ready is the sink's accept
//   eol/eof            - last pixel of line / frame qualifiers
module pixel_stream_tx
    import pixel_stream_tx_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_data,
    output logic              data_valid,
    output logic [PIX_W-1:0]  data_o,
    input  logic              ready,
    output logic              eol,
    output logic              eof
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  addr;
    logic               rd_en;
    logic               rd_pend;
    logic               rd_eol;
    logic               rd_eof;
    logic               frame_done_q;
    logic               last_col;
    logic               last_px;
    logic               buf_valid;
    logic [PIX_W+1:0]   buf_data;
    logic [1:0]         buf_level;
    logic               pop;
    logic               room;

    assign last_col = (col == COL_W'(IMG_W - 1));
    assign last_px  = last_col && (row == ROW_W'(IMG_H - 1));
    assign pop      = buf_valid && ready;

    // Buffered entries plus the read in flight, minus what leaves this cycle,
    // must leave a slot free for one more read.
    assign room = ({1'b0, buf_level} + {2'b00, rd_pend}) <= (3'd1 + {2'b00, pop});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The first read is issued in the start cycle itself so the first pixel
    // reaches data_o two cycles after start. A start landing on the
    // frame_done cycle is dropped.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !frame_done_q) begin
                    rd_en     = 1'b1;
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (room) begin
                    rd_en = 1'b1;
                    if (last_px) begin
                        state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (pop && buf_data[PIX_W+1]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counters wrap back to zero on the last read, so a new frame always
    // starts at address 0 without an explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            addr         <= '0;
            rd_pend      <= 1'b0;
            rd_eol       <= 1'b0;
            rd_eof       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rd_pend      <= rd_en;
            frame_done_q <= (state == ST_FLUSH) && pop && buf_data[PIX_W+1];
            if (rd_en) begin
                rd_eol <= last_col;
                rd_eof <= last_px;
                if (last_col) begin
                    col <= '0;
                    row <= last_px ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
                addr <= last_px ? '0 : addr + ADDR_W'(1);
            end
        end
    end

    // Read data and its line/frame flags enter the buffer together one cycle
    // after the strobe; a read pending at reset is lost with rd_pend.
    skid_buf2 #(
        .W(PIX_W + 2)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_pend),
        .in_data   ({rd_eof, rd_eol, mem_data}),
        .out_valid (buf_valid),
        .out_data  (buf_data),
        .out_ready (ready),
        .level     (buf_level)
    );

    assign mem_rd_en  = rd_en && !rst;
    assign mem_addr   = addr;
    assign busy       = (state != ST_IDLE);
    assign frame_done = frame_done_q;
    assign data_valid = buf_valid;
    assign data_o     = buf_data[PIX_W-1:0];
    assign eol        = buf_valid && buf_data[PIX_W];
    assign eof        = buf_valid && buf_data[PIX_W+1];

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb/tb_pixel_stream_tx.sv - self-checking bench for pixel_stream_tx on a 4x4 frame
module tb_pixel_stream_tx;

    localparam int IW = 4;
    localparam int IH = 4;
    localparam int N  = IW * IH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic       busy, frame_done, mem_rd_en, data_valid, eol, eof;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] data_o;

    logic [7:0] mem [0:N-1];

    int errors = 0;
    int checks = 0;

    logic [7:0] got_d[$];
    bit         got_eol[$];
    bit         got_eof[$];
    int         got_c[$];
    int rd_cnt, done_c, done_cnt, first_v, stab_err, max_fly, post_busy, post_rd;
    bit timed_out, busy_done, aborted, rst_out_bad;

    pixel_stream_tx #(.IMG_W(IW), .IMG_H(IH), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .data_valid (data_valid),
        .data_o     (data_o),
        .ready      (ready),
        .eol        (eol),
        .eof        (eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= mem[mem_addr];
    end

    // Reference pixel k of a frame: memory word k, eol at end of every row, eof on the last.
    function automatic logic [9:0] ref_px(input int k);
        return {k == N - 1, (k % IW) == IW - 1, mem[k]};
    endfunction

    // Drives one frame and records what the sink sees; comparisons live in the test tasks.
    task automatic run_frame(input int mode, input bit busy_start, input bit done_start, input int abort_at);
        bit prev_stall = 0;
        logic [9:0] prev = '0;
        int fly;
        got_d.delete(); got_eol.delete(); got_eof.delete(); got_c.delete();
        rd_cnt = 0; done_c = -1; done_cnt = 0; first_v = -1; stab_err = 0; max_fly = 0;
        timed_out = 0; busy_done = 0; aborted = 0; rst_out_bad = 0; post_busy = 0; post_rd = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (frame_done) begin
                done_cnt++;
                if (done_c < 0) begin done_c = c; busy_done = busy; end
            end
            start = (c == 0) || (busy_start && c == 5) || (done_start && frame_done);
            case (mode)
                0: ready = 1'b1;
                1: ready = !(c >= 3 && c <= 6);
                2: ready = c[0];
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (abort_at >= 0 && got_d.size() == abort_at) begin
                rst = 1'b1;
                #1;
                rst_out_bad = ({busy, frame_done, mem_rd_en, data_valid, eol, eof} != 6'd0)
                              || (mem_addr != 4'd0) || (data_o != 8'd0);
                aborted = 1;
                break;
            end
            #1;
            if (prev_stall && !(data_valid && {eof, eol, data_o} === prev)) stab_err++;
            if (mem_rd_en) rd_cnt++;
            if (data_valid && first_v < 0) first_v = c;
            if (data_valid && ready) begin
                got_d.push_back(data_o);
                got_eol.push_back(eol);
                got_eof.push_back(eof);
                got_c.push_back(c);
            end
            fly = rd_cnt - got_d.size();
            if (fly > max_fly) max_fly = fly;
            prev_stall = data_valid && !ready;
            prev = {eof, eol, data_o};
            if (done_c >= 0) break;
        end
        if (done_c < 0 && !aborted) timed_out = 1;
        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            start = 1'b0;
            if (aborted && p == 2) rst = 1'b0;
            #1;
            if (busy) post_busy++;
            if (mem_rd_en) post_rd++;
            if (frame_done) done_cnt++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({busy, frame_done, mem_rd_en, data_valid, eol, eof} !== 6'd0)
            begin errors++; $display("FAIL reset_flags: got %b expected 000000", {busy, frame_done, mem_rd_en, data_valid, eol, eof}); end
        checks++;
        if ({mem_addr, data_o} !== 12'd0)
            begin errors++; $display("FAIL reset_bus: got addr=%0d data=%0d expected 0/0", mem_addr, data_o); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, mem_rd_en, data_valid} !== 3'd0)
            begin errors++; $display("FAIL idle_after_reset: got %b expected 000", {busy, mem_rd_en, data_valid}); end
    endtask

    task automatic test_ready_high();
        for (int k = 0; k < N; k++) mem[k] = 8'(k);
        run_frame(0, 0, 0, -1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL rh_timeout: got no frame_done expected one"); end
        checks++;
        if (got_d.size() != N) begin errors++; $display("FAIL rh_count: got %0d expected %0d", got_d.size(), N); end
        for (int k = 0; k < got_d.size() && k < N; k++) begin
            checks++;
            if ({got_eof[k], got_eol[k], got_d[k]} !== ref_px(k))
                begin errors++; $display("FAIL rh_px%0d: got %h expected %h", k, {got_eof[k], got_eol[k], got_d[k]}, ref_px(k)); end
            checks++;
            if (got_c[k] != 2 + k) begin errors++; $display("FAIL rh_cycle%0d: got %0d expected %0d", k, got_c[k], 2 + k); end
        end
        checks++;
        if (first_v != 2) begin errors++; $display("FAIL rh_latency: got %0d expected 2", first_v); end
        checks++;
        if (done_c != N + 2) begin errors++; $display("FAIL rh_done_cycle: got %0d expected %0d", done_c, N + 2); end
        checks++;
        if (busy_done) begin errors++; $display("FAIL rh_busy_at_done: got 1 expected 0"); end
        checks++;
        if (rd_cnt != N) begin errors++; $display("FAIL rh_reads: got %0d expected %0d", rd_cnt, N); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL rh_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_stall();
        for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
        run_frame(1, 0, 0, -1);
        checks++;
        if (got_d.size() != N) begin errors++; $display("FAIL st_count: got %0d expected %0d", got_d.size(), N); end
        for (int k = 0; k < got_d.size() && k < N; k++) begin
            checks++;
            if ({got_eof[k], got_eol[k], got_d[k]} !== ref_px(k))
                begin errors++; $display("FAIL st_px%0d: got %h expected %h", k, {got_eof[k], got_eol[k], got_d[k]}, ref_px(k)); end
        end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL st_stable: got %0d unstable cycles expected 0", stab_err); end
        checks++;
        if (max_fly > 2) begin errors++; $display("FAIL st_depth: got %0d pixels held expected at most 2", max_fly); end
        checks++;
        if (done_c != N + 6) begin errors++; $display("FAIL st_done_cycle: got %0d expected %0d", done_c, N + 6); end
    endtask

    task automatic test_toggle();
        for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
        run_frame(2, 0, 0, -1);
        checks++;
        if (got_d.size() != N) begin errors++; $display("FAIL tg_count: got %0d expected %0d", got_d.size(), N); end
        for (int k = 0; k < got_d.size() && k < N; k++) begin
            checks++;
            if ({got_eof[k], got_eol[k], got_d[k]} !== ref_px(k))
                begin errors++; $display("FAIL tg_px%0d: got %h expected %h", k, {got_eof[k], got_eol[k], got_d[k]}, ref_px(k)); end
        end
        checks++;
        if (done_c != 2 * N + 2) begin errors++; $display("FAIL tg_done_cycle: got %0d expected %0d", done_c, 2 * N + 2); end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL tg_stable: got %0d expected 0", stab_err); end
    endtask

    task automatic test_random_ready();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
            run_frame(3, 0, 0, -1);
            checks++;
            if (got_d.size() != N || rd_cnt != N)
                begin errors++; $display("FAIL rr%0d_count: got xfers=%0d reads=%0d expected %0d", r, got_d.size(), rd_cnt, N); end
            for (int k = 0; k < got_d.size() && k < N; k++) begin
                checks++;
                if ({got_eof[k], got_eol[k], got_d[k]} !== ref_px(k))
                    begin errors++; $display("FAIL rr%0d_px%0d: got %h expected %h", r, k, {got_eof[k], got_eol[k], got_d[k]}, ref_px(k)); end
            end
            checks++;
            if (stab_err != 0 || max_fly > 2)
                begin errors++; $display("FAIL rr%0d_hold: got unstable=%0d depth=%0d expected 0 and <=2", r, stab_err, max_fly); end
        end
    endtask

    task automatic test_busy_start();
        for (int k = 0; k < N; k++) mem[k] = 8'(k);
        run_frame(0, 1, 0, -1);
        checks++;
        if (got_d.size() != N || rd_cnt != N)
            begin errors++; $display("FAIL bs_count: got xfers=%0d reads=%0d expected %0d", got_d.size(), rd_cnt, N); end
        for (int k = 0; k < got_d.size() && k < N; k++) begin
            checks++;
            if (got_d[k] !== 8'(k)) begin errors++; $display("FAIL bs_px%0d: got %0d expected %0d", k, got_d[k], k); end
        end
        checks++;
        if (done_c != N + 2 || post_busy != 0)
            begin errors++; $display("FAIL bs_done: got done_c=%0d post_busy=%0d expected %0d/0", done_c, post_busy, N + 2); end
    endtask

    task automatic test_done_start();
        run_frame(0, 0, 1, -1);
        checks++;
        if (post_busy != 0) begin errors++; $display("FAIL ds_busy: got %0d busy cycles expected 0", post_busy); end
        checks++;
        if (post_rd != 0 || rd_cnt != N)
            begin errors++; $display("FAIL ds_reads: got post=%0d total=%0d expected 0/%0d", post_rd, rd_cnt, N); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL ds_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_abort();
        for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
        run_frame(0, 0, 0, 7);
        checks++;
        if (!aborted) begin errors++; $display("FAIL ab_reached: got 0 expected 1"); end
        checks++;
        if (rst_out_bad) begin errors++; $display("FAIL ab_outputs: got nonzero expected all 0"); end
        checks++;
        if (done_cnt != 0 || post_busy != 0)
            begin errors++; $display("FAIL ab_no_done: got done=%0d busy=%0d expected 0/0", done_cnt, post_busy); end
        run_frame(0, 0, 0, -1);
        checks++;
        if (got_d.size() != N) begin errors++; $display("FAIL ab_restart_count: got %0d expected %0d", got_d.size(), N); end
        for (int k = 0; k < got_d.size() && k < N; k++) begin
            checks++;
            if ({got_eof[k], got_eol[k], got_d[k]} !== ref_px(k))
                begin errors++; $display("FAIL ab_px%0d: got %h expected %h", k, {got_eof[k], got_eol[k], got_d[k]}, ref_px(k)); end
        end
    endtask

    initial begin
        test_reset();
        test_ready_high();
        test_stall();
        test_toggle();
        test_random_ready();
        test_busy_start();
        test_done_start();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
